// File: rtl/uart_pkg.sv
// Shared definitions for the UART subsystem reset controller: sequencer state
// encoding and the default hold/stagger timing.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_t;

    localparam int DEF_N_STAGES    = 3;
    localparam int DEF_HOLD_CYC    = 16;
    localparam int DEF_STAGGER_CYC = 4;
    localparam int DEF_CW          = 8;

    function automatic int max_cyc(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Warm-reset handshake and sequenced reset outputs of the UART reset controller,
// plus the sequencer state for observation.
interface rst_sequencer_if
    import uart_pkg::*;
#(
    parameter int N_STAGES = DEF_N_STAGES
);
    // Handshake: the requester raises sw_rst_req (level) while sys_ready is high; the
    // sequencer takes it on the next clock edge and later answers with a one-cycle
    // sw_rst_ack, at which point the requester drops sw_rst_req. A request seen outside
    // RUN is ignored, not queued.
    logic                sw_rst_req;
    logic                sw_rst_ack;
    logic [N_STAGES-1:0] stage_rst;
    logic                sys_ready;
    logic                seq_busy;
    seq_state_t          state;

    modport master (
        output sw_rst_req,
        input  sw_rst_ack, stage_rst, sys_ready, seq_busy, state
    );

    modport slave (
        input  sw_rst_req,
        output sw_rst_ack, stage_rst, sys_ready, seq_busy, state
    );

endinterface

// File: rtl/rst_sync_2ff.sv
// Two-flop reset synchronizer: asserts asynchronously with rst low, deasserts
// rst_s (active high) on the second clock edge after rst rises.
module rst_sync_2ff (
    input  logic clk,
    input  logic rst,
    output logic rst_s
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_s = ~sync_q[1];

endmodule

// File: rtl/rst_sequencer.sv
// UART subsystem reset controller: holds every block in reset, then releases the
// per-block resets one by one; a warm reset from software replays the same sequence.
module rst_sequencer
    import uart_pkg::*;
#(
    parameter int N_STAGES    = DEF_N_STAGES,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int STAGGER_CYC = DEF_STAGGER_CYC,
    parameter int CW          = DEF_CW
) (
    input  logic            clk,
    input  logic            rst,
    rst_sequencer_if.slave  bus
);

    localparam int SW = $clog2(N_STAGES + 1);

    localparam logic [CW-1:0]       HOLD_T  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0]       STAG_T  = CW'(STAGGER_CYC - 1);
    localparam logic [SW-1:0]       STG_END = SW'(N_STAGES);
    localparam logic [N_STAGES-1:0] ONE     = N_STAGES'(1);

    logic                rst_s;
    seq_state_t          state_q;
    logic [CW-1:0]       cnt_q;
    logic [SW-1:0]       stg_q;
    logic                sw_flag_q;
    logic [N_STAGES-1:0] stage_rst_q;
    logic                sys_ready_q;
    logic                seq_busy_q;
    logic                ack_q;

    rst_sync_2ff u_sync (
        .clk   (clk),
        .rst   (rst),
        .rst_s (rst_s)
    );

    // While the synchronizer still holds rst_s, the sequencer sits at its reset values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            stg_q       <= '0;
            sw_flag_q   <= 1'b0;
            stage_rst_q <= '1;
            sys_ready_q <= 1'b0;
            seq_busy_q  <= 1'b1;
            ack_q       <= 1'b0;
        end else if (rst_s) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            stg_q       <= '0;
            sw_flag_q   <= 1'b0;
            stage_rst_q <= '1;
            sys_ready_q <= 1'b0;
            seq_busy_q  <= 1'b1;
            ack_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_T) begin
                        cnt_q       <= '0;
                        stage_rst_q <= stage_rst_q & ~ONE;
                        stg_q       <= SW'(1);
                        state_q     <= ST_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // Once the last stage is out, spend one edge entering RUN.
                    if (stg_q == STG_END) begin
                        cnt_q       <= '0;
                        state_q     <= ST_RUN;
                        sys_ready_q <= 1'b1;
                        seq_busy_q  <= 1'b0;
                        ack_q       <= sw_flag_q;
                        sw_flag_q   <= 1'b0;
                    end else if (cnt_q == STAG_T) begin
                        cnt_q       <= '0;
                        stage_rst_q <= stage_rst_q & ~(ONE << stg_q);
                        stg_q       <= stg_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.sw_rst_req) begin
                        cnt_q       <= '0;
                        stg_q       <= '0;
                        sw_flag_q   <= 1'b1;
                        stage_rst_q <= '1;
                        sys_ready_q <= 1'b0;
                        seq_busy_q  <= 1'b1;
                        state_q     <= ST_HOLD;
                    end
                end
                default: begin
                    state_q <= ST_HOLD;
                end
            endcase
        end
    end

    assign bus.stage_rst  = stage_rst_q;
    assign bus.sys_ready  = sys_ready_q;
    assign bus.seq_busy   = seq_busy_q;
    assign bus.sw_rst_ack = ack_q;
    assign bus.state      = state_q;

endmodule
